// File: rtl/v850_mem_responder.sv
// v850_mem_responder: single-outstanding load/store responder over a little-endian word array.
// Optional feature macro V850_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of being aligned.
module v850_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_sign,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_range_err;
    logic          w_misalign;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_rdata;
    logic [31:0]   w_wmask;
    logic [31:0]   w_wword;
    logic          w_commit;

    always_comb begin
        w_range_err = (r_addr[31:2] >= 30'(DEPTH_WORDS));
        w_misalign  = 1'b0;
`ifdef V850_MISALIGN_TRAP_EN
        w_misalign  = ((r_size == 2'd1) && r_addr[0]) ||
                      ((r_size == 2'd2) && (r_addr[1:0] != 2'b00));
`endif
        w_err = (r_size == 2'd3) || w_range_err || w_misalign;
        w_idx = r_addr[AW+1:2];

        // Without the trap, misaligned halfwords/words are silently aligned by lane choice.
        case (r_size)
            2'd0:    w_lane = r_addr[1:0];
            2'd1:    w_lane = {r_addr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase

        w_word = r_mem[w_idx];
        w_byte = w_word[{w_lane, 3'b000} +: 8];
        w_half = w_word[{w_lane[1], 4'b0000} +: 16];

        case (r_size)
            2'd0:    w_rdata = r_sign ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            2'd1:    w_rdata = r_sign ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            default: w_rdata = w_word;
        endcase

        case (r_size)
            2'd0:    w_wmask = 32'h0000_00FF << {w_lane, 3'b000};
            2'd1:    w_wmask = 32'h0000_FFFF << {w_lane, 3'b000};
            default: w_wmask = 32'hFFFF_FFFF;
        endcase
        w_wword = (w_word & ~w_wmask) | ((r_wdata << {w_lane, 3'b000}) & w_wmask);

        w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
    end

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_commit && r_write && !w_err) begin
            r_mem[w_idx] <= w_wword;
        end
    end

    // WAIT always lasts WAIT_STATES+1 cycles so the response rises N+1+WAIT_STATES edges after acceptance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'h0;
            r_size      <= 2'd0;
            r_sign      <= 1'b0;
            r_wdata     <= 32'h0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'h0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_write <= i_req_write;
                        r_addr  <= i_req_addr;
                        r_size  <= i_req_size;
                        r_sign  <= i_req_sign;
                        r_wdata <= i_req_wdata;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= w_err;
                        o_rsp_rdata <= (w_err || r_write) ? 32'h0 : w_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        o_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE) && !i_rst;

endmodule

// File: tb/tb_v850_mem_responder.sv
// Self-checking bench for v850_mem_responder: directed cases plus random traffic against a byte-level model.
`timescale 1ns/1ps
module tb_v850_mem_responder;
    localparam int DEPTH = 1024;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_sign = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mdl [0:4*DEPTH-1];

    always #5 clk = ~clk;

    v850_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_size  (req_size),
        .i_req_sign  (req_sign),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: fault rules, alignment, then byte-wise read/write.
    function automatic void mdl_access(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                                       input bit sgn, input logic [31:0] wd,
                                       output logic [31:0] rd, output bit err);
        int unsigned nb, base;
        logic [31:0] v;
        rd  = 32'h0;
        err = (size == 2'd3) || (addr >= 32'(4*DEPTH));
`ifdef V850_MISALIGN_TRAP_EN
        if (size == 2'd1 && addr % 2 != 0) err = 1'b1;
        if (size == 2'd2 && addr % 4 != 0) err = 1'b1;
`endif
        if (err) return;
        nb   = 1 << size;
        base = addr - (addr % nb);
        if (wr) begin
            for (int i = 0; i < nb; i++) mdl[base+i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(mdl[base+i]) << (8*i));
            if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            rd = v;
        end
    endfunction

    // Entered at a falling edge; returns at the falling edge right after the response handshake.
    task automatic run_req(input string tag, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                           input bit sgn, input logic [31:0] wd, input int hold, input bit early,
                           input bit use_exp, input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] m_rd;
        bit          m_err;
        int          cyc;
        mdl_access(wr, addr, size, sgn, wd, m_rd, m_err);
        if (use_exp) begin
            m_rd  = exp_rd;
            m_err = exp_err;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
        req_sign = sgn; req_wdata = wd;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = $urandom; req_addr = $urandom; req_size = 2'($urandom);
        req_wdata = $urandom;
        if (early) rsp_ready = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) break;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(WS + 2));
        chk({tag, ".rdata"}, rsp_rdata, m_rd);
        chk({tag, ".err"}, 32'(rsp_err), 32'(m_err));
        if (!early) begin
            for (int k = 0; k < hold; k++) begin
                req_valid = 1'b1;
                @(negedge clk);
                chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, ".hold_rdata"}, rsp_rdata, m_rd);
                chk({tag, ".hold_err"}, 32'(rsp_err), 32'(m_err));
                chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".post_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        logic [31:0] prior20;

        repeat (2) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.release_ready", 32'(req_ready), 32'd1);

        for (int w = 0; w < 64; w++)
            run_req("fill", 1'b1, 32'(w*4), 2'd2, 1'b0, $urandom, 0, 1'b0, 1'b0, 32'h0, 1'b0);

        run_req("sw10", 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, 1'b0, 1'b1, 32'h0, 1'b0);
        run_req("lw10", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        run_req("sb13", 1'b1, 32'h13, 2'd0, 1'b0, 32'h80, 0, 1'b0, 1'b1, 32'h0, 1'b0);
        run_req("ldb13", 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0);
        run_req("ldbu13", 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h00000080, 1'b0);
        run_req("lw10b", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h80ADBEEF, 1'b0);
`ifdef V850_MISALIGN_TRAP_EN
        run_req("lh11", 1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 1'b1);
`else
        run_req("lh11", 1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0000BEEF, 1'b0);
`endif
        run_req("sw_oor", 1'b1, 32'(4*DEPTH), 2'd2, 1'b0, 32'hA5A5A5A5, 0, 1'b0, 1'b1, 32'h0, 1'b1);
        run_req("lw0_after_oor", 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_req("st_size3", 1'b1, 32'h10, 2'd3, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 1'b1);
        run_req("ld_size3", 1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 1'b1);
        run_req("lw10_hold", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, 1'b0, 1'b1, 32'h80ADBEEF, 1'b0);
        run_req("lw10_early", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 1'b1, 1'b1, 32'h80ADBEEF, 1'b0);

        // Reset in the middle of a store's wait: nothing may be written.
        prior20 = {mdl[32'h23], mdl[32'h22], mdl[32'h21], mdl[32'h20]};
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 2'd2;
        req_sign = 1'b0; req_wdata = ~prior20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstw.rdata", rsp_rdata, 32'd0);
        chk("rstw.err", 32'(rsp_err), 32'd0);
        chk("rstw.req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_req("lw20_after_rst", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, 1'b0, 1'b1, prior20, 1'b0);

        for (int n = 0; n < 150; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) a = 32'(4*DEPTH) + 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 31) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            r = $urandom_range(0, 3);
            run_req("rand", 1'($urandom), a, sz, 1'($urandom), $urandom,
                    (r == 3) ? 0 : r, (r == 3), 1'b0, 32'h0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
